// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Generates VGA raster timing from a fast system clock. A divider produces
// one dot-enable every CLK_DIV cycles. Horizontal and vertical counters walk
// the raster. Every output is registered from the region decode of the
// counter state in a dot-enable cycle. Strobes are therefore exactly one
// i_clk wide, and level outputs change only on dot boundaries.
//
// Ports:
//   i_clk            system clock
//   i_reset_n        asynchronous active-low reset
//   i_enable         1 = timing runs; 0 = counters freeze and strobes are 0
//   o_hsync_pin      monitor HSYNC (polarity set by SYNC_ACTIVE_LOW)
//   o_vsync_pin      monitor VSYNC (polarity set by SYNC_ACTIVE_LOW)
//   o_hsync          strobe: first dot of horizontal sync
//   o_vsync          strobe: first dot of the first vertical-sync line
//   o_screen_reset   strobe: last dot of the frame
//   o_pixel_x_clock  strobe: advance to the next logical pixel
//   o_pixel_y_clock  strobe: last dot of a visible line
//   o_active         1 while the current dot is visible
//   o_x, o_y         current dot column / line while active, else 0
// ---------------------------------------------------------------------------
module vga_timing_generator #(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned X_SCALE         = 20,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  output logic       o_hsync_pin,
  output logic       o_vsync_pin,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_screen_reset,
  output logic       o_pixel_x_clock,
  output logic       o_pixel_y_clock,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [9:0] o_y
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Minimum widths that hold TOTAL-1. Never narrower than one bit.
  localparam int unsigned H_W   = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned V_W   = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SUB_W = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic SYNC_ON  = !SYNC_ACTIVE_LOW;
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  logic [DIV_W-1:0] div_cnt;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [SUB_W-1:0] sub_cnt;

  // Zero-extended copies, so every compare is a plain 32-bit unsigned one.
  logic [31:0] div32, h32, v32, sub32;

  logic dot_en;
  logic h_last, v_last, sub_last, h_act_end, h_vis;
  logic active, hs, vs;

  // NOTE: a combinational block assigns every output on every path. That is
  // why no latch can be inferred here.
  always_comb begin
    div32     = 32'(div_cnt);
    h32       = 32'(h_cnt);
    v32       = 32'(v_cnt);
    sub32     = 32'(sub_cnt);

    dot_en    = i_enable && (div32 == CLK_DIV - 1);

    h_last    = (h32 == H_TOTAL - 1);
    v_last    = (v32 == V_TOTAL - 1);
    sub_last  = (sub32 == X_SCALE - 1);
    h_act_end = (h32 == H_ACTIVE - 1);
    h_vis     = (h32 < H_ACTIVE);

    active    = h_vis && (v32 < V_ACTIVE);
    hs        = (h32 >= HS_START) && (h32 < HS_END);
    vs        = (v32 >= VS_START) && (v32 < VS_END);
  end

  // Raster counters. While i_enable is low they all hold. Resuming then
  // continues from the exact dot and sub-dot phase where they stopped.
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      sub_cnt <= '0;
    end else if (i_enable) begin
      div_cnt <= dot_en ? '0 : div_cnt + DIV_W'(1);
      if (dot_en) begin
        h_cnt <= h_last ? '0 : h_cnt + H_W'(1);
        if (h_last) begin
          v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
        end
        // Clearing at the last visible dot makes every line start a fresh
        // logical pixel. This holds even when H_ACTIVE is not a multiple of
        // X_SCALE.
        if (h_last || h_act_end) begin
          sub_cnt <= '0;
        end else if (h_vis) begin
          sub_cnt <= sub_last ? '0 : sub_cnt + SUB_W'(1);
        end
      end
    end
  end

  // Output registers. Strobes fall back to 0 in every cycle without a dot
  // enable. Level outputs keep their value until the next dot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hsync_pin     <= SYNC_OFF;
      o_vsync_pin     <= SYNC_OFF;
      o_hsync         <= 1'b0;
      o_vsync         <= 1'b0;
      o_screen_reset  <= 1'b0;
      o_pixel_x_clock <= 1'b0;
      o_pixel_y_clock <= 1'b0;
      o_active        <= 1'b0;
      o_x             <= '0;
      o_y             <= '0;
    end else if (dot_en) begin
      o_hsync_pin     <= hs ? SYNC_ON : SYNC_OFF;
      o_vsync_pin     <= vs ? SYNC_ON : SYNC_OFF;
      o_hsync         <= (h32 == HS_START);
      o_vsync         <= (h32 == 0) && (v32 == VS_START);
      o_screen_reset  <= h_last && v_last;
      // The last visible dot never advances x: there is no pixel after it.
      o_pixel_x_clock <= active && sub_last && !h_act_end;
      o_pixel_y_clock <= h_act_end && (v32 < V_ACTIVE);
      o_active        <= active;
      o_x             <= active ? 10'(h_cnt) : '0;
      o_y             <= active ? 10'(v_cnt) : '0;
    end else begin
      o_hsync         <= 1'b0;
      o_vsync         <= 1'b0;
      o_screen_reset  <= 1'b0;
      o_pixel_x_clock <= 1'b0;
      o_pixel_y_clock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
//
// Three instances share one clock, reset and enable:
//   A: default parameters (640x480 at CLK_DIV=4, X_SCALE=20).
//   B: tiny raster, CLK_DIV=1, H 8/1/2/1, V 4/1/1/1, X_SCALE=2, pins active
//      high. Checked dot by dot against a hand-computed vector table.
//   C: small raster, CLK_DIV=4, H 16/2/4/3, V 6/1/2/2, X_SCALE=5. It runs
//      whole frames within a short cycle budget. It is also used for the
//      enable-pause and asynchronous-reset sequences.
// Inputs are driven and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

  logic i_clk = 1'b0;
  logic i_reset_n;
  logic i_enable;

  always #5 i_clk = ~i_clk;

  logic a_hp, a_vp, a_hs, a_vs, a_sr, a_xc, a_yc, a_act;
  logic [9:0] a_x, a_y;
  logic b_hp, b_vp, b_hs, b_vs, b_sr, b_xc, b_yc, b_act;
  logic [9:0] b_x, b_y;
  logic c_hp, c_vp, c_hs, c_vs, c_sr, c_xc, c_yc, c_act;
  logic [9:0] c_x, c_y;

  vga_timing_generator u_a (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .o_hsync_pin(a_hp), .o_vsync_pin(a_vp), .o_hsync(a_hs), .o_vsync(a_vs),
    .o_screen_reset(a_sr), .o_pixel_x_clock(a_xc), .o_pixel_y_clock(a_yc),
    .o_active(a_act), .o_x(a_x), .o_y(a_y)
  );

  vga_timing_generator #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .X_SCALE(2),
    .SYNC_ACTIVE_LOW(1'b0)
  ) u_b (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .o_hsync_pin(b_hp), .o_vsync_pin(b_vp), .o_hsync(b_hs), .o_vsync(b_vs),
    .o_screen_reset(b_sr), .o_pixel_x_clock(b_xc), .o_pixel_y_clock(b_yc),
    .o_active(b_act), .o_x(b_x), .o_y(b_y)
  );

  vga_timing_generator #(
    .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .X_SCALE(5),
    .SYNC_ACTIVE_LOW(1'b1)
  ) u_c (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .o_hsync_pin(c_hp), .o_vsync_pin(c_vp), .o_hsync(c_hs), .o_vsync(c_vs),
    .o_screen_reset(c_sr), .o_pixel_x_clock(c_xc), .o_pixel_y_clock(c_yc),
    .o_active(c_act), .o_x(c_x), .o_y(c_y)
  );

  // Instance C geometry: 25 dots per line, 11 lines, 4 clocks per dot.
  localparam int C_HT  = 25;
  localparam int C_VT  = 11;
  localparam int C_DIV = 4;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Expected outputs of instance B after the dot with linear index 'dot'
  // (dot = 12*v + h). Pins are active high in B.
  typedef struct {
    int dot;
    bit hs, vs, sr, xc, yc, act, hp, vp;
    int x, y;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  int a_cnt_xc, a_cnt_hs, a_cnt_yc, a_cnt_hpl;
  int b_cnt_xc, b_cnt_hs, b_cnt_vs, b_cnt_sr, b_cnt_yc, b_bad;
  int c_cnt_xc, c_cnt_hs, c_cnt_vs, c_cnt_sr, c_cnt_yc, c_cnt_hpl, c_cnt_vpl;
  int vidx, bh, bv;
  int k, first, strobes_seen, x_moved, first_hs, first_sr, vs_before_sr;
  logic [7:0] b_flags, b_exp;

  initial begin
    //            dot hs vs sr xc yc act hp vp  x  y
    vec[0]  = '{  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vec[1]  = '{  1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    vec[2]  = '{  2, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0};
    vec[3]  = '{  3, 0, 0, 0, 1, 0, 1, 0, 0, 3, 0};
    vec[4]  = '{  5, 0, 0, 0, 1, 0, 1, 0, 0, 5, 0};
    vec[5]  = '{  7, 0, 0, 0, 0, 1, 1, 0, 0, 7, 0};
    vec[6]  = '{  8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[7]  = '{  9, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vec[8]  = '{ 10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vec[9]  = '{ 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[10] = '{ 15, 0, 0, 0, 1, 0, 1, 0, 0, 3, 1};
    vec[11] = '{ 43, 0, 0, 0, 0, 1, 1, 0, 0, 7, 3};
    vec[12] = '{ 55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[13] = '{ 60, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vec[14] = '{ 69, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    vec[15] = '{ 72, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[16] = '{ 83, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vec[17] = '{ 84, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vec[18] = '{ 85, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0};

    a_cnt_xc = 0; a_cnt_hs = 0; a_cnt_yc = 0; a_cnt_hpl = 0;
    b_cnt_xc = 0; b_cnt_hs = 0; b_cnt_vs = 0; b_cnt_sr = 0; b_cnt_yc = 0; b_bad = 0;
    c_cnt_xc = 0; c_cnt_hs = 0; c_cnt_vs = 0; c_cnt_sr = 0; c_cnt_yc = 0;
    c_cnt_hpl = 0; c_cnt_vpl = 0;
    vidx = 0;

    // ---------------- reset state ----------------
    i_reset_n = 1'b0;
    i_enable  = 1'b1;
    step();
    step();
    check("A reset strobes/active", {a_hs, a_vs, a_sr, a_xc, a_yc, a_act}, 0);
    check("A reset pins", {a_hp, a_vp}, 2'b11);
    check("A reset x/y", {a_x, a_y}, 0);
    check("B reset strobes/active", {b_hs, b_vs, b_sr, b_xc, b_yc, b_act}, 0);
    check("B reset pins (active high)", {b_hp, b_vp}, 2'b00);
    check("C reset pins", {c_hp, c_vp}, 2'b11);
    i_reset_n = 1'b1;

    // ---------------- free run from release ----------------
    // After posedge n, dot index d of an instance is visible when
    // n = CLK_DIV*(d+1) ... CLK_DIV*(d+2)-1.
    for (int n = 1; n <= 3200; n++) begin
      step();

      // A: o_x tracks h one clock after the dot_en cycle holding h.
      if (n == 23)   check("A o_x before dot 5", a_x, 4);
      if (n == 24)   check("A o_x at dot 5", a_x, 5);
      if (n == 2563) check("A active at h=639", {a_act, a_x}, {1'b1, 10'd639});
      if (n == 2564) check("A active falls after h=640", {a_act, a_x}, 0);
      a_cnt_xc  += int'(a_xc);
      a_cnt_hs  += int'(a_hs);
      a_cnt_yc  += int'(a_yc);
      a_cnt_hpl += int'(!a_hp);

      // B: one dot per clock, so the visible dot is n-1.
      if (n <= 84) begin
        bh = (n - 1) % 12;
        bv = (n - 1) / 12;
        b_cnt_xc += int'(b_xc);
        b_cnt_hs += int'(b_hs);
        b_cnt_vs += int'(b_vs);
        b_cnt_sr += int'(b_sr);
        b_cnt_yc += int'(b_yc);
        if (b_xc && !((bh == 1 || bh == 3 || bh == 5) && bv < 4)) b_bad++;
        if (b_yc && !(bh == 7 && bv < 4)) b_bad++;
        if (b_sr && !(bh == 11 && bv == 6)) b_bad++;
      end
      if (vidx < NV && (n - 1) == vec[vidx].dot) begin
        b_flags = {b_hs, b_vs, b_sr, b_xc, b_yc, b_act, b_hp, b_vp};
        b_exp   = {vec[vidx].hs, vec[vidx].vs, vec[vidx].sr, vec[vidx].xc,
                   vec[vidx].yc, vec[vidx].act, vec[vidx].hp, vec[vidx].vp};
        check($sformatf("B dot %0d flags{hs,vs,sr,xc,yc,act,hp,vp}", vec[vidx].dot),
              b_flags, b_exp);
        check($sformatf("B dot %0d o_x", vec[vidx].dot), b_x, vec[vidx].x);
        check($sformatf("B dot %0d o_y", vec[vidx].dot), b_y, vec[vidx].y);
        vidx++;
      end

      // C: two full frames are visible by posedge 2200.
      if (n <= 2200) begin
        c_cnt_xc  += int'(c_xc);
        c_cnt_hs  += int'(c_hs);
        c_cnt_vs  += int'(c_vs);
        c_cnt_sr  += int'(c_sr);
        c_cnt_yc  += int'(c_yc);
        c_cnt_hpl += int'(!c_hp);
        c_cnt_vpl += int'(!c_vp);
      end
    end

    check("A x clocks in line 0", a_cnt_xc, 31);
    check("A hsync strobes in line 0", a_cnt_hs, 1);
    check("A y clocks in line 0", a_cnt_yc, 1);
    check("A hsync pin low clocks per line", a_cnt_hpl, 96 * 4);

    check("B x clocks per frame", b_cnt_xc, 12);
    check("B hsync per frame", b_cnt_hs, 7);
    check("B vsync per frame", b_cnt_vs, 1);
    check("B screen_reset per frame", b_cnt_sr, 1);
    check("B y clocks per frame", b_cnt_yc, 4);
    check("B strobes at wrong position", b_bad, 0);

    check("C x clocks in 2 frames", c_cnt_xc, 3 * 6 * 2);
    check("C hsync in 2 frames", c_cnt_hs, C_VT * 2);
    check("C vsync in 2 frames", c_cnt_vs, 2);
    check("C screen_reset in 2 frames", c_cnt_sr, 2);
    check("C y clocks in 2 frames", c_cnt_yc, 6 * 2);
    check("C hsync pin low clocks", c_cnt_hpl, 4 * C_DIV * C_VT * 2);
    check("C vsync pin low clocks", c_cnt_vpl, 2 * C_HT * C_DIV * 2);

    // ---------------- enable pause mid-line (C) ----------------
    i_reset_n = 1'b0;
    step();
    i_reset_n = 1'b1;
    first = -1;
    for (int t = 1; t <= 200 && first < 0; t++) begin
      step();
      if (c_hs) first = t;
    end
    // The first hsync shows one clock after the dot_en cycle of h=18.
    check("C first hsync posedge", first, (18 + 1) * C_DIV);
    for (k = 1; k <= 50; k++) step();
    k = 50;
    // Line 1, h=5 is visible here.
    check("C o_x before pause", c_x, 5);
    check("C o_y/active before pause", {c_act, c_y}, {1'b1, 10'd1});
    i_enable     = 1'b0;
    strobes_seen = 0;
    x_moved      = 0;
    for (int t = 0; t < 37; t++) begin
      step();
      if ({c_hs, c_vs, c_sr, c_xc, c_yc} != 5'b0) strobes_seen++;
      if (c_x != 10'd5) x_moved++;
    end
    check("C strobes while disabled", strobes_seen, 0);
    check("C o_x moved while disabled", x_moved, 0);
    i_enable = 1'b1;
    k = 87;
    first = -1;
    while (k < 400 && first < 0) begin
      step();
      k++;
      if (c_hs) first = k;
    end
    check("C hsync spacing across pause", first, C_HT * C_DIV + 37);

    // ---------------- asynchronous reset mid-line (C) ----------------
    first = -1;
    for (int t = 0; t < 400 && first < 0; t++) begin
      step();
      if (c_act && c_x >= 10'd3) first = t;
    end
    check("C reached mid active line", int'(first >= 0), 1);
    #1 i_reset_n = 1'b0;
    #1;
    check("C async reset strobes/active", {c_hs, c_vs, c_sr, c_xc, c_yc, c_act}, 0);
    check("C async reset x/y", {c_x, c_y}, 0);
    check("C async reset pins", {c_hp, c_vp}, 2'b11);
    @(negedge i_clk);
    i_reset_n    = 1'b1;
    first_hs     = -1;
    first_sr     = -1;
    vs_before_sr = 0;
    for (int e = 1; e <= 1500 && first_sr < 0; e++) begin
      step();
      if (e == 3) check("C active still low at posedge 3", c_act, 0);
      if (e == 4) check("C dot 0 at posedge 4", {c_act, c_x, c_y}, {1'b1, 20'd0});
      if (e == 8) check("C dot 1 at posedge 8", {c_act, c_x, c_y}, {1'b1, 10'd1, 10'd0});
      if (c_hs && first_hs < 0) first_hs = e;
      if (c_vs) vs_before_sr++;
      if (c_sr) first_sr = e;
    end
    check("C first hsync after reset", first_hs, (18 + 1) * C_DIV);
    check("C vsync count before screen_reset", vs_before_sr, 1);
    // Counted from the first posedge after release.
    check("C first screen_reset after reset", first_sr - 1, C_VT * C_HT * C_DIV - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
